// File: rtl/disp_scan_pkg.sv
// Shared constants and types for the four-digit display scanner.
package disp_scan_pkg;

    localparam int DIGITS  = 4;
    localparam int NIB_W   = 4;
    localparam int VALUE_W = DIGITS * NIB_W;

    localparam logic [DIGITS-1:0] AN_OFF = 4'b1111;

    typedef struct packed {
        logic [VALUE_W-1:0] value;
        logic [DIGITS-1:0]  points;
    } disp_word_t;

    localparam disp_word_t DISP_WORD_ZERO = '{value: '0, points: '0};

    function automatic logic [NIB_W-1:0] nibble_of(input logic [VALUE_W-1:0] v,
                                                   input logic [1:0] k);
        logic [NIB_W-1:0] n;
        n = '0;
        case (k)
            2'd0: n = v[3:0];
            2'd1: n = v[7:4];
            2'd2: n = v[11:8];
            2'd3: n = v[15:12];
            default: n = '0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/disp_prescaler.sv
// Free-running digit-slot prescaler; tick marks the last cycle of a slot,
// dead marks the first (anode dead time).
module disp_prescaler #(
    parameter int PRESCALE_W = 17
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick,
    output logic dead
);

    logic [PRESCALE_W-1:0] presc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    assign tick = &presc;
    assign dead = (presc == '0);

endmodule

// File: rtl/disp_scan.sv
// Four-digit multiplexed display scanner feeding a hex-to-7-segment decoder.
// Define DISP_SCAN_LZB_EN to enable leading-zero blanking of digits 3..1.
module disp_scan
    import disp_scan_pkg::*;
#(
    parameter int PRESCALE_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       value,
    input  logic [3:0]        points,
    input  logic              load,
    output logic              pending,
    output logic              D0,
    output logic              D1,
    output logic              D2,
    output logic              D3,
    output logic              point,
    output logic              LE,
    output logic [3:0]        AN,
    output logic              frame_tick
);

    logic       tick;
    logic       dead;
    logic [1:0] dig;
    disp_word_t shadow;
    disp_word_t pend;
    logic       pend_flag;
    disp_word_t incoming;

    logic [NIB_W-1:0]  nib;
    logic [DIGITS-1:0] an_sel;
    logic [DIGITS-1:0] blank;

    disp_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .dead  (dead)
    );

    assign frame_tick = tick && (dig == 2'd3);
    assign incoming   = '{value: value, points: points};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig <= 2'd0;
        end else if (tick) begin
            dig <= dig + 2'd1;
        end
    end

    // A load on the frame edge itself bypasses pend so it shows next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= DISP_WORD_ZERO;
            pend      <= DISP_WORD_ZERO;
            pend_flag <= 1'b0;
        end else if (frame_tick) begin
            if (load) begin
                shadow    <= incoming;
                pend_flag <= 1'b0;
            end else if (pend_flag) begin
                shadow    <= pend;
                pend_flag <= 1'b0;
            end
        end else if (load) begin
            pend      <= incoming;
            pend_flag <= 1'b1;
        end
    end

`ifdef DISP_SCAN_LZB_EN
    always_comb begin
        logic hi_zero;
        blank   = '0;
        hi_zero = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            hi_zero  = hi_zero && (nibble_of(shadow.value, 2'(k)) == '0);
            blank[k] = hi_zero && !shadow.points[k];
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        an_sel = ~(4'b0001 << dig);
        if (dead) begin
            AN = AN_OFF;
        end else begin
            AN = an_sel | blank;
        end
    end

    assign nib     = nibble_of(shadow.value, dig);
    assign D0      = nib[0];
    assign D1      = nib[1];
    assign D2      = nib[2];
    assign D3      = nib[3];
    assign point   = shadow.points[dig];
    assign LE      = 1'b0;
    assign pending = pend_flag;

endmodule

// File: tb/tb_disp_scan.sv
// Randomised self-checking bench for disp_scan against a cycle-count based reference model.
module tb_disp_scan;

    localparam int PW    = 2;
    localparam int SLOT  = 1 << PW;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  points = '0;
    logic        load = 1'b0;
    logic        pending;
    logic        D0, D1, D2, D3;
    logic        point;
    logic        LE;
    logic [3:0]  AN;
    logic        frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: cycles since reset, displayed word, latest undelivered load
    int          m_cyc;
    logic [15:0] m_val;
    logic [3:0]  m_pts;
    logic [15:0] m_pval;
    logic [3:0]  m_ppts;
    bit          m_pv;
    bit          seen_1111;
    bit          seen_2222;

    disp_scan #(.PRESCALE_W(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .points     (points),
        .load       (load),
        .pending    (pending),
        .D0         (D0),
        .D1         (D1),
        .D2         (D2),
        .D3         (D3),
        .point      (point),
        .LE         (LE),
        .AN         (AN),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc  = 0;
        m_val  = '0;
        m_pts  = '0;
        m_pval = '0;
        m_ppts = '0;
        m_pv   = 0;
    endtask

    task automatic model_edge();
        bit frame_end;
        frame_end = (m_cyc % FRAME) == FRAME - 1;
        if (load) begin
            if (frame_end) begin
                m_val = value;
                m_pts = points;
                m_pv  = 0;
            end else begin
                m_pval = value;
                m_ppts = points;
                m_pv   = 1;
            end
        end else if (frame_end && m_pv) begin
            m_val = m_pval;
            m_pts = m_ppts;
            m_pv  = 0;
        end
        m_cyc++;
    endtask

    task automatic check_outputs();
        int          presc;
        int          d;
        logic [3:0]  exp_an;
        logic [3:0]  exp_d;
        presc  = m_cyc % SLOT;
        d      = (m_cyc / SLOT) % 4;
        exp_d  = 4'((m_val >> (4 * d)) & 16'hF);
        exp_an = 4'hF & ~(4'd1 << d);
`ifdef DISP_SCAN_LZB_EN
        if (d > 0 && (m_val >> (4 * d)) == 0 && m_pts[d] == 1'b0) exp_an = 4'hF;
`endif
        if (presc == 0) exp_an = 4'hF;
        chk("an", 32'(AN), 32'(exp_an));
        chk("d", 32'({D3, D2, D1, D0}), 32'(exp_d));
        chk("point", 32'(point), 32'(m_pts[d]));
        chk("pending", 32'(pending), 32'(m_pv));
        chk("frame_tick", 32'(frame_tick), 32'((m_cyc % FRAME) == FRAME - 1));
        chk("le", 32'(LE), 32'd0);
        if ({D3, D2, D1, D0} == 4'h1 && m_val == 16'h1111) seen_1111 = 1;
        if ({D3, D2, D1, D0} == 4'h2 && m_val == 16'h2222) seen_2222 = 1;
    endtask

    // one clock: model follows the edge, then outputs are sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic run_idle(input int cycles);
        load = 1'b0;
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] p);
        value  = v;
        points = p;
        load   = 1'b1;
        step();
        load   = 1'b0;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        load  = 1'b0;
        #1;
        model_reset();
        chk("rst_an", 32'(AN), 32'hF);
        chk("rst_d", 32'({D3, D2, D1, D0}), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_point", 32'(point), 32'd0);
        chk("rst_frame_tick", 32'(frame_tick), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_outputs();
    endtask

    initial begin
        model_reset();
        seen_1111 = 0;
        seen_2222 = 0;
        #2;
        check_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_outputs();

        // idle scan after reset
        run_idle(20);

        // mid-frame load of 1A3F / point on digit 2
        do_load(16'h1A3F, 4'b0100);
        chk("pending_after_load", 32'(pending), 32'd1);
        run_idle(36);
        chk("shown_1a3f", 32'(m_val), 32'h1A3F);

        // two loads in one frame, last wins
        while ((m_cyc % FRAME) != 2) step();
        do_load(16'h1111, 4'b0000);
        run_idle(3);
        do_load(16'h2222, 4'b0000);
        run_idle(FRAME * 2);
        chk("never_1111", 32'(seen_1111), 32'd0);
        chk("seen_2222", 32'(seen_2222), 32'd1);

        // load exactly on the frame_tick edge
        while ((m_cyc % FRAME) != FRAME - 1) step();
        chk("on_edge_tick", 32'(frame_tick), 32'd1);
        do_load(16'h00C0, 4'b0000);
        chk("on_edge_pending", 32'(pending), 32'd0);
        run_idle(FRAME + 2);

        // reset mid-frame with a pending load
        while ((m_cyc % FRAME) != 6) step();
        do_load(16'hBEEF, 4'b1010);
        run_idle(2);
        chk("pend_before_rst", 32'(pending), 32'd1);
        reset_pulse();
        run_idle(FRAME * 2);

        // randomised traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                reset_pulse();
            end else if ($urandom_range(0, 7) == 0) begin
                value  = 16'($urandom) & (($urandom_range(0, 1) == 0) ? 16'h00FF : 16'hFFFF);
                points = 4'($urandom);
                load   = 1'b1;
                step();
            end else begin
                load = 1'b0;
                step();
            end
        end
        load = 1'b0;
        run_idle(FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/disp_scan.md
# disp_scan

Four-digit time-multiplexed display scanner that sits directly upstream of the team's MC14495-style hex-to-7-segment decoder. It holds a 16-bit hex value and four decimal-point bits, and cycles one digit at a time onto the decoder's D0..D3/point/LE inputs. It also drives the active-low common-anode selects. New values are loaded through a strobe and only take effect at a frame boundary, so the display never shows a torn value.

## Interface
Parameters:
- PRESCALE_W, default 17: prescaler width; each digit slot lasts 2^PRESCALE_W clk cycles (≈763 Hz per digit at 100 MHz).

Ports:
- clk  in  1  system clock; one clock domain; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- value  in  16  hex value; digit k = value[4k+3:4k]; digit 0 is rightmost.
- points  in  4  decimal point per digit; bit k belongs to digit k; 1 = lit.
- load  in  1  capture strobe for value/points; sampled every cycle.
- pending  out  1  high while a captured load waits for the frame boundary.
- D0, D1, D2, D3  out  1 each  nibble of the active digit, D0 = LSB; feeds decoder D0..D3.
- point  out  1  decimal point of the active digit; feeds decoder point.
- LE  out  1  decoder latch enable; held 0 (transparent).
- AN  out  4  anode selects, active-low; AN[k]=0 lights digit k.
- frame_tick  out  1  one-cycle pulse in the last cycle of each frame.

## Operation
- State registers:
  - presc: PRESCALE_W bits.
  - dig: 2 bits.
  - shadow: 16 + 4 bits, the value and points being displayed.
  - pend: 16 + 4 bits, the captured load.
  - pend_flag: 1 bit.
- All outputs are decoded from registers only; there is no combinational path from value, points or load to any output.
- tick = (presc == all-ones). presc increments every cycle and wraps to 0.
- On each tick edge, dig advances 0→1→2→3→0.
- frame_tick = tick && dig==3. A frame is 4·2^PRESCALE_W cycles.
- D3..D0 = shadow nibble[dig]; point = shadow points[dig].
- AN = ~(1<<dig), except dead time: AN = 4'b1111 whenever presc==0. This suppresses ghosting.
- Load handling:
  - load=1 captures value/points into pend and sets pend_flag. Repeated loads overwrite pend; the last one wins.
  - At a frame_tick edge with pend_flag=1, shadow takes pend and pend_flag clears.
  - If load=1 on a frame_tick edge, the incoming value/points go straight to shadow and pend_flag clears. A stale pend is discarded.
- pending = pend_flag.
- LE = 0 at all times.

## Timing
- Reset values: presc=0, dig=0, shadow=0, pend=0, pend_flag=0.
- Outputs during and immediately after reset: D=0000, point=0, LE=0, AN=1111 (dead time, because presc=0), pending=0, frame_tick=0.
- Reset mid-frame aborts the frame immediately and discards any pending load.
- Load-to-pending latency: pending rises the cycle after the load edge.
- Load-to-display latency: from 1 cycle (load on a frame_tick edge) up to one full frame.
- Digit change: the new digit appears the cycle after the tick edge, with AN=1111 for exactly that one cycle.

## Configuration
- DISP_SCAN_LZB_EN defined: leading-zero blanking.
  - Any digit k>0 whose nibble and all higher nibbles of shadow are zero, and whose point bit is 0, is blanked with AN[k]=1.
  - Digit 0 is always shown.
  - D and point are still driven.
- DISP_SCAN_LZB_EN undefined: all four digits are always lit outside dead time.

## Structure
- Package disp_scan_pkg holds:
  - DIGITS=4, NIB_W=4.
  - AN_OFF=4'b1111.
  - typedef disp_word_t: the 16-bit value plus 4 points.
- One sub-module: disp_prescaler.
  - Owns presc.
  - Outputs tick and dead (presc==0).
  - Parameterised by PRESCALE_W.

## Test plan
All scenarios use PRESCALE_W=2, giving 4-cycle slots and 16-cycle frames.
- Reset release with load=0: AN = 1111, 1110, 1110, 1110, then 1111, 1101…; D=0000 throughout; frame_tick pulses every 16 cycles.
- Load value=16'h1A3F, points=4'b0100 mid-frame: pending=1 until frame_tick. The next frame shows digits F,3,A,1 on D3..D0, with point=1 only while dig=2. pending then drops.
- Two loads in one frame (16'h1111, then 16'h2222): only 2222 is ever displayed.
- Load 16'h00C0 exactly on the frame_tick edge: shown from the next cycle; pending stays 0.
- rst_n low for 1 cycle mid-frame with a load pending: AN=1111, D=0, pending=0 asynchronously; the old value is never shown.
- With DISP_SCAN_LZB_EN, value=16'h00C0, points=0: AN[3] and AN[2] stay 1 all frame; digits 1 and 0 light.
